regfile_bist: RTL and testbench



---
 rtl/regfile_bist_pkg.sv | 23 ++
 rtl/regfile_bist.sv | 153 +++++++++++++++
 tb/tb_regfile_bist.sv | 237 +++++++++++++++++++++++
 3 files changed

// File: rtl/regfile_bist_pkg.sv
// Shared types, constants and pattern helper for the register-file BIST.
// Optional feature macro: REGFILE_BIST_INV_PASS_EN (adds the inverted-pattern pass).
package regfile_bist_pkg;

    localparam int          NUM_REGS_DEFAULT = 8;
    localparam logic [31:0] PAT_MULT         = 32'h0000_1111;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WR   = 2'd1,
        RD   = 2'd2,
        DONE = 2'd3
    } state_t;

    // Test pattern for address a: (a+1) * 0x1111, bit-inverted when inv is set.
    // Returned at 32 bits; callers keep the low DATA_W bits.
    function automatic logic [31:0] pat(input logic [31:0] a, input logic inv);
        logic [31:0] p;
        p = (a + 32'd1) * PAT_MULT;
        return inv ? ~p : p;
    endfunction

endpackage

// File: rtl/regfile_bist.sv
// Register-file BIST initiator: writes a pattern to every entry, reads it back
// through ports A and B, and reports a verdict plus the first failing address.
// Optional feature macro: REGFILE_BIST_INV_PASS_EN -- when defined, a second
// pass repeats the write/read sweep with the inverted pattern.
//
// Handshake: Start is a level sampled only in IDLE; an accepted Start raises
// Busy from the next edge, and Busy stays high through WR, RD and DONE. Done is
// a one-cycle pulse in DONE; Pass/FailAddr hold their values from Done until
// the next accepted Start. Start outside IDLE is dropped, never queued.
module regfile_bist
    import regfile_bist_pkg::*;
#(
    parameter int DATA_W   = 16,
    parameter int ADDR_W   = 4,
    parameter int NUM_REGS = NUM_REGS_DEFAULT
) (
    input  logic              CLK,
    input  logic              RST_N,
    input  logic              Start,
    output logic              Busy,
    output logic              Done,
    output logic              Pass,
    output logic [ADDR_W-1:0] FailAddr,
    output logic              RfWrite,
    output logic [ADDR_W-1:0] RfWriteAddr,
    output logic [DATA_W-1:0] RfDataIn,
    output logic [ADDR_W-1:0] RfReadAddrA,
    output logic [ADDR_W-1:0] RfReadAddrB,
    input  logic [DATA_W-1:0] RfReadDataA,
    input  logic [DATA_W-1:0] RfReadDataB,
    output state_t            DbgState
);

    state_t            state, nextState;
    logic [ADDR_W-1:0] addr, nextAddr, addrNext;
    logic              passReg, nextPass;
    logic [ADDR_W-1:0] failReg, nextFail;
    logic              lastAddr;
    logic              inv;
    logic [31:0]       patA, patB;
    logic [DATA_W-1:0] expA, expB;

`ifdef REGFILE_BIST_INV_PASS_EN
    logic passCnt, nextPassCnt;
    assign inv = passCnt;
`else
    assign inv = 1'b0;
`endif

    // The wrap at the last tested entry is explicit so NUM_REGS need not be a power of two.
    assign lastAddr = (addr == ADDR_W'(NUM_REGS - 1));
    assign addrNext = lastAddr ? '0 : addr + ADDR_W'(1);
    assign patA     = pat(32'(addr), inv);
    assign patB     = pat(32'(addrNext), inv);
    assign expA     = patA[DATA_W-1:0];
    assign expB     = patB[DATA_W-1:0];

    assign Pass     = passReg;
    assign FailAddr = failReg;
    assign DbgState = state;

    // State, address counter, verdict registers (and pass counter when enabled).
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state   <= IDLE;
            addr    <= '0;
            passReg <= 1'b0;
            failReg <= '0;
`ifdef REGFILE_BIST_INV_PASS_EN
            passCnt <= 1'b0;
`endif
        end else begin
            state   <= nextState;
            addr    <= nextAddr;
            passReg <= nextPass;
            failReg <= nextFail;
`ifdef REGFILE_BIST_INV_PASS_EN
            passCnt <= nextPassCnt;
`endif
        end
    end

    // Next-state logic and register-file port drive; ports idle at 0 outside their phase.
    always_comb begin
        nextState   = state;
        nextAddr    = addr;
        nextPass    = passReg;
        nextFail    = failReg;
`ifdef REGFILE_BIST_INV_PASS_EN
        nextPassCnt = passCnt;
`endif
        Busy        = (state != IDLE);
        Done        = 1'b0;
        RfWrite     = 1'b0;
        RfWriteAddr = '0;
        RfDataIn    = '0;
        RfReadAddrA = '0;
        RfReadAddrB = '0;
        case (state)
            IDLE: begin
                if (Start) begin
                    nextState   = WR;
                    nextAddr    = '0;
                    nextPass    = 1'b0;
                    nextFail    = '0;
`ifdef REGFILE_BIST_INV_PASS_EN
                    nextPassCnt = 1'b0;
`endif
                end
            end
            WR: begin
                RfWrite     = 1'b1;
                RfWriteAddr = addr;
                RfDataIn    = expA;
                nextAddr    = addrNext;
                if (lastAddr) nextState = RD;
            end
            RD: begin
                RfReadAddrA = addr;
                RfReadAddrB = addrNext;
                nextAddr    = addrNext;
                if (RfReadDataA != expA) begin
                    nextState = DONE;
                    nextPass  = 1'b0;
                    nextFail  = addr;
                end else if (RfReadDataB != expB) begin
                    nextState = DONE;
                    nextPass  = 1'b0;
                    nextFail  = addrNext;
                end else if (lastAddr) begin
`ifdef REGFILE_BIST_INV_PASS_EN
                    if (!passCnt) begin
                        nextState   = WR;
                        nextPassCnt = 1'b1;
                    end else begin
                        nextState = DONE;
                        nextPass  = 1'b1;
                    end
`else
                    nextState = DONE;
                    nextPass  = 1'b1;
`endif
                end
            end
            DONE: begin
                Done      = 1'b1;
                nextState = IDLE;
            end
            default: nextState = IDLE;
        endcase
    end

endmodule

// File: tb/tb_regfile_bist.sv
// Self-checking bench for regfile_bist: a behavioural register-file model with
// injectable faults, a run-level reference model, and a write scoreboard.
module tb_regfile_bist;
    import regfile_bist_pkg::*;

    localparam int DW = 16;
    localparam int AW = 4;
    localparam int N  = 8;
`ifdef REGFILE_BIST_INV_PASS_EN
    localparam int NUM_PASSES = 2;
`else
    localparam int NUM_PASSES = 1;
`endif

    logic          CLK, RST_N, Start;
    logic          Busy, Done, Pass, RfWrite;
    logic [AW-1:0] FailAddr, RfWriteAddr, RfReadAddrA, RfReadAddrB;
    logic [DW-1:0] RfDataIn, RfReadDataA, RfReadDataB;
    state_t        dbgState;

    int checks   = 0;
    int failures = 0;

    logic [AW+DW-1:0] exp_q[$];
    bit               monEn;

    logic [DW-1:0] rf [0:N-1];
    int            faultKind, faultReg, faultBit;
    bit            faultVal;

    regfile_bist #(.DATA_W(DW), .ADDR_W(AW), .NUM_REGS(N)) dut (
        .CLK(CLK), .RST_N(RST_N), .Start(Start),
        .Busy(Busy), .Done(Done), .Pass(Pass), .FailAddr(FailAddr),
        .RfWrite(RfWrite), .RfWriteAddr(RfWriteAddr), .RfDataIn(RfDataIn),
        .RfReadAddrA(RfReadAddrA), .RfReadAddrB(RfReadAddrB),
        .RfReadDataA(RfReadDataA), .RfReadDataB(RfReadDataB),
        .DbgState(dbgState)
    );

    // clock / reset block
    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic checkVal(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
        end
    endtask

    // Fault behaviour of the register file: 0 none, 1 stuck bit, 2 entry reads zero.
    function automatic logic [DW-1:0] faultRead(input int a, input logic [DW-1:0] v,
                                                input int kind, input int r, input int b, input bit sv);
        logic [DW-1:0] o;
        o = v;
        if (kind == 1 && a == r) o[b] = sv;
        if (kind == 2 && a == r) o = '0;
        return o;
    endfunction

    function automatic logic [DW-1:0] refPat(input int a, input int p);
        int v;
        v = ((a + 1) * 4369) % 65536;
        if (p != 0) v = 65535 - v;
        return DW'(v);
    endfunction

    // register-file model: synchronous write, combinational read
    always @(posedge CLK) if (RfWrite) rf[RfWriteAddr[2:0]] <= RfDataIn;
    assign RfReadDataA = faultRead(int'(RfReadAddrA), rf[RfReadAddrA[2:0]], faultKind, faultReg, faultBit, faultVal);
    assign RfReadDataB = faultRead(int'(RfReadAddrB), rf[RfReadAddrB[2:0]], faultKind, faultReg, faultBit, faultVal);

    // write scoreboard
    always @(negedge CLK) begin
        if (monEn && RST_N && RfWrite) begin
            if (exp_q.size() == 0) begin
                checkVal("wr_unexpected", 32'd1, 32'd0);
            end else begin
                logic [AW+DW-1:0] e;
                e = exp_q.pop_front();
                checkVal("wr_addr", 32'(RfWriteAddr), 32'(e[AW+DW-1:DW]));
                checkVal("wr_data", 32'(RfDataIn), 32'(e[DW-1:0]));
            end
        end
    end

    // Run-level reference: expected writes, Done offset from the Start edge, verdict.
    task automatic modelRun(output int off, output bit expPass, output int expFail);
        logic [DW-1:0] mem [0:N-1];
        bit stop;
        stop = 0;
        off = NUM_PASSES * 2 * N;
        expPass = 1;
        expFail = 0;
        for (int p = 0; p < NUM_PASSES && !stop; p++) begin
            for (int a = 0; a < N; a++) begin
                mem[a] = refPat(a, p);
                exp_q.push_back({AW'(a), mem[a]});
            end
            for (int a = 0; a < N && !stop; a++) begin
                int b;
                b = (a + 1) % N;
                if (faultRead(a, mem[a], faultKind, faultReg, faultBit, faultVal) != refPat(a, p)) begin
                    stop = 1; expPass = 0; expFail = a; off = p * 2 * N + N + a + 1;
                end else if (faultRead(b, mem[b], faultKind, faultReg, faultBit, faultVal) != refPat(b, p)) begin
                    stop = 1; expPass = 0; expFail = b; off = p * 2 * N + N + a + 1;
                end
            end
        end
    endtask

    // driver: one full run, checking every cycle until Done and the first IDLE cycle
    task automatic doRun(input int kind, input int r, input int b, input bit sv, input bit holdStart);
        int off, expFail;
        bit expPass, seen;
        faultKind = kind; faultReg = r; faultBit = b; faultVal = sv;
        modelRun(off, expPass, expFail);
        if (!Start) begin
            @(negedge CLK);
            Start = 1'b1;
        end
        @(posedge CLK);
        #1;
        if (!holdStart) Start = 1'b0;
        seen = 0;
        for (int n = 0; n <= off + 4 && !seen; n++) begin
            @(negedge CLK);
            if (n == 0) begin
                checkVal("busy_start", 32'(Busy), 32'd1);
                checkVal("pass_clear", 32'(Pass), 32'd0);
                checkVal("failaddr_clear", 32'(FailAddr), 32'd0);
            end
            if (n < off) begin
                int w;
                w = n % (2 * N);
                checkVal("done_early", 32'(Done), 32'd0);
                checkVal("rf_write", 32'(RfWrite), (w < N) ? 32'd1 : 32'd0);
                checkVal("rd_addr_a", 32'(RfReadAddrA), (w < N) ? 32'd0 : 32'(w - N));
                checkVal("rd_addr_b", 32'(RfReadAddrB), (w < N) ? 32'd0 : 32'((w - N + 1) % N));
            end
            if (Done) begin
                seen = 1;
                checkVal("done_cycle", 32'(n), 32'(off));
                checkVal("pass", 32'(Pass), 32'(expPass));
                checkVal("fail_addr", 32'(FailAddr), 32'(expFail));
                checkVal("done_wr_off", 32'(RfWrite), 32'd0);
                checkVal("done_busy", 32'(Busy), 32'd1);
            end
        end
        if (!seen) checkVal("done_timeout", 32'd0, 32'd1);
        @(negedge CLK);
        checkVal("busy_idle", 32'(Busy), 32'd0);
        checkVal("done_pulse", 32'(Done), 32'd0);
        checkVal("pass_hold", 32'(Pass), 32'(expPass));
        checkVal("failaddr_hold", 32'(FailAddr), 32'(expFail));
        checkVal("wr_queue_empty", 32'(exp_q.size()), 32'd0);
        exp_q.delete();
    endtask

    // driver: reset asserted in cycle k+5 of a run
    task automatic resetMidRun();
        monEn = 0;
        faultKind = 0;
        @(negedge CLK);
        Start = 1'b1;
        @(posedge CLK);
        #1;
        Start = 1'b0;
        for (int n = 0; n < 5; n++) begin
            @(negedge CLK);
            checkVal("pre_rst_write", 32'(RfWrite), 32'd1);
        end
        @(negedge CLK);
        RST_N = 1'b0;
        #1;
        checkVal("rst_write", 32'(RfWrite), 32'd0);
        checkVal("rst_busy", 32'(Busy), 32'd0);
        checkVal("rst_done", 32'(Done), 32'd0);
        checkVal("rst_pass", 32'(Pass), 32'd0);
        checkVal("rst_wdata", 32'(RfDataIn), 32'd0);
        @(negedge CLK);
        RST_N = 1'b1;
        @(negedge CLK);
        checkVal("rst_idle", 32'(Busy), 32'd0);
        exp_q.delete();
        monEn = 1;
    endtask

    initial begin
        for (int i = 0; i < N; i++) rf[i] = '0;
        faultKind = 0; faultReg = 0; faultBit = 0; faultVal = 0;
        monEn = 1;
        Start = 1'b0;
        RST_N = 1'b0;
        repeat (2) @(negedge CLK);
        checkVal("reset_busy", 32'(Busy), 32'd0);
        checkVal("reset_done", 32'(Done), 32'd0);
        checkVal("reset_pass", 32'(Pass), 32'd0);
        checkVal("reset_failaddr", 32'(FailAddr), 32'd0);
        checkVal("reset_write", 32'(RfWrite), 32'd0);
        checkVal("reset_outs", 32'({RfWriteAddr, RfDataIn, RfReadAddrA, RfReadAddrB}), 32'd0);
        RST_N = 1'b1;
        @(negedge CLK);

        doRun(0, 0, 0, 0, 0);        // fault-free
        doRun(1, 3, 0, 0, 0);        // reg 3 bit 0 stuck at 0
        doRun(2, 0, 0, 0, 0);        // reg 0 reads zero
        resetMidRun();
        doRun(0, 0, 0, 0, 0);        // full run after reset release
        doRun(0, 0, 0, 0, 1);        // Start held for the whole run
        doRun(0, 0, 0, 0, 0);        // accepted in the first IDLE cycle
        doRun(2, 7, 0, 0, 0);        // last entry bad: port B at a=6

        for (int t = 0; t < 10; t++) begin
            int gap;
            gap = int'($urandom_range(0, 3));
            for (int g = 0; g < gap; g++) begin
                @(negedge CLK);
                checkVal("idle_gap_busy", 32'(Busy), 32'd0);
            end
            doRun(int'($urandom_range(0, 2)), int'($urandom_range(0, N - 1)),
                  int'($urandom_range(0, DW - 1)), bit'($urandom_range(0, 1)), 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // global time limit
    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish, checks=%0d", checks);
        $fatal(1, "timeout");
    end

endmodule
